// File: rtl/grf_pkg.sv
// Package for the general register file with integrated scoreboard.
// Holds the default geometry of the register file and the address of the
// hard-wired zero register.
package grf_pkg;
   localparam int GRF_DATA_W = 32;   // register width
   localparam int GRF_ADDR_W = 5;    // 32 architectural registers
   localparam int GRF_CNT_W  = 2;    // up to 3 in-flight writes per register
   localparam int REG_ZERO   = 0;    // address of the constant-zero register
endpackage

// File: rtl/grf_pending_ctr.sv
// Pending-write counter for one register.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   inc         - issue request for this register (ignored at max)
//   dec         - number of write-backs retiring this register this cycle
//   cnt         - current number of in-flight writes
//   at_max      - counter saturated; further issues are not accepted
//   uflow       - pulse: more write-backs arrived than were pending
module grf_pending_ctr
   import grf_pkg::*;
#(
   parameter int CNT_W = GRF_CNT_W,
   parameter int DEC_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic [DEC_W-1:0] dec,
   output logic [CNT_W-1:0] cnt,
   output logic             at_max,
   output logic             uflow
);
   // Wide enough for both operands plus one spare bit so no compare wraps.
   localparam int W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     cnt_x, dec_x, dec_c, sum;

   assign at_max = (cnt_q == MAX);

   always_comb begin
      cnt_x = W'(cnt_q);
      dec_x = W'(dec);
      // Retire at most what is pending; the excess is reported as underflow.
      dec_c = (dec_x > cnt_x) ? cnt_x : dec_x;
      sum   = cnt_x + W'(inc && !at_max) - dec_c;
      cnt_d = CNT_W'(sum);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt   = cnt_q;
   assign uflow = (dec_x > cnt_x);
endmodule

// File: rtl/grf_mp_sb.sv
// Multi-port general register file with write-to-read bypass and an
// integrated per-register pending-write scoreboard.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   rd_addr      - NUM_RD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data      - NUM_RD combinational read data, bypassed from write-back
//   rd_busy      - per read port: source still has writes pending after this cycle
//   wr_en/addr/data - NUM_WR write-back ports, higher index wins on conflict
//   iss_en/addr  - allocate one pending write on iss_addr
//   iss_ready    - iss_addr counter below max
//   err_uflow    - sticky: write-back arrived with nothing pending
module grf_mp_sb
   import grf_pkg::*;
#(
   parameter int DATA_W  = GRF_DATA_W,
   parameter int ADDR_W  = GRF_ADDR_W,
   parameter int NUM_RD  = 3,
   parameter int NUM_WR  = 2,
   parameter int CNT_W   = GRF_CNT_W,
   parameter int ZERO_R0 = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_ready,
   output logic                     err_uflow
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int DEC_W = $clog2(NUM_WR+1);
   localparam int CW    = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(REG_ZERO);

   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [NUM_RD-1:0][DATA_W-1:0] rd;
   logic [NUM_WR-1:0][ADDR_W-1:0] wa;
   logic [NUM_WR-1:0][DATA_W-1:0] wd;

   assign ra      = rd_addr;
   assign wa      = wr_addr;
   assign wd      = wr_data;
   assign rd_data = rd;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  at_max_v, uflow_v, busy_v;
   logic              err_q;

   // Scoreboard: one counter per register. r0 (when masked) never sees
   // inc/dec, so it stays at 0: never busy, always ready, no underflow.
   for (genvar a = 0; a < DEPTH; a++) begin : g_reg
      localparam bit LIVE = !(ZERO_R0 != 0 && a == REG_ZERO);
      logic [DEC_W-1:0] dec;
      logic [CNT_W-1:0] cnt;
      logic             inc;

      always_comb begin
         dec = '0;
         for (int p = 0; p < NUM_WR; p++)
            if (LIVE && wr_en[p] && wa[p] == ADDR_W'(a)) dec = dec + DEC_W'(1);
      end

      assign inc = LIVE && iss_en && (iss_addr == ADDR_W'(a));

      grf_pending_ctr #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_ctr (
         .clk    (clk),
         .reset  (reset),
         .inc    (inc),
         .dec    (dec),
         .cnt    (cnt),
         .at_max (at_max_v[a]),
         .uflow  (uflow_v[a])
      );

      // Busy means writes remain after this cycle's retirements; a same-cycle
      // issue is deliberately not visible here.
      assign busy_v[a] = CW'(cnt) > CW'(dec);
   end

   // Storage: ports are scanned low to high so the highest enabled port to a
   // given address is the last assignment and wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && !(ZERO_R0 != 0 && wa[p] == R0)) regs_q[wa[p]] <= wd[p];
      end
   end

   // Read ports with same-cycle bypass, same priority order as the write.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rd[k] = regs_q[ra[k]];
         for (int p = 0; p < NUM_WR; p++)
            if (wr_en[p] && wa[p] == ra[k]) rd[k] = wd[p];
         if (ZERO_R0 != 0 && ra[k] == R0) rd[k] = '0;
         rd_busy[k] = busy_v[ra[k]];
      end
   end

   assign iss_ready = !at_max_v[iss_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         err_q <= 1'b0;
      else if (|uflow_v) err_q <= 1'b1;
   end

   assign err_uflow = err_q;
endmodule

// File: tb/tb_grf_mp_sb.sv
// Scoreboard bench for grf_mp_sb (default parameters).
module tb_grf_mp_sb;
   logic          clk = 1'b0;
   logic          reset;
   logic [14:0]   rd_addr;
   logic [95:0]   rd_data;
   logic [2:0]    rd_busy;
   logic [1:0]    wr_en;
   logic [9:0]    wr_addr;
   logic [63:0]   wr_data;
   logic          iss_en;
   logic [4:0]    iss_addr;
   logic          iss_ready;
   logic          err_uflow;

   grf_mp_sb dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .err_uflow(err_uflow)
   );

   always #5 clk = ~clk;

   // Observation selectors: 0..2 rd_data[k], 3..5 rd_busy[k], 6 iss_ready, 7 err_uflow
   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  n_chk = 0;
   int  n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         0, 1, 2: obs = rd_data[sel*32 +: 32];
         3, 4, 5: obs = {31'b0, rd_busy[sel-3]};
         6:       obs = {31'b0, iss_ready};
         default: obs = {31'b0, err_uflow};
      endcase
   endfunction

   task automatic exp_o(input string tag, input int sel, input logic [31:0] v);
      sb_t e;
      e.tag = tag; e.sel = sel; e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic drain;
      sb_t e;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, obs(e.sel), e.exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      rd_addr[k*5 +: 5] = a;
   endtask

   task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]          = en;
      wr_addr[p*5 +: 5] = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic idle;
      wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      rd_addr = '0;
      idle();
      #1 reset = 1'b1;
      // reset state
      set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); iss_addr = 5'd5;
      for (int k = 0; k < 3; k++) begin
         exp_o("rst_data", k, 32'h0);
         exp_o("rst_busy", 3 + k, 32'h0);
      end
      exp_o("rst_ready", 6, 32'h1);
      exp_o("rst_err", 7, 32'h0);
      drain();
      #10 reset = 1'b0;
      tick();

      // r5: issue, busy, bypassed retire, stored
      iss_en = 1'b1; iss_addr = 5'd5;
      exp_o("r5_ready", 6, 32'h1);
      drain();
      tick();
      iss_en = 1'b0; set_rd(0, 5'd5);
      exp_o("r5_busy", 3, 32'h1);
      drain();
      set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      exp_o("r5_byp", 0, 32'hDEAD_BEEF);
      exp_o("r5_byp_busy", 3, 32'h0);
      drain();
      tick();
      idle();
      exp_o("r5_stored", 0, 32'hDEAD_BEEF);
      exp_o("r5_idle_busy", 3, 32'h0);
      drain();

      // r7: two ports same address, higher index wins
      iss_en = 1'b1; iss_addr = 5'd7;
      tick(); tick();
      idle();
      set_wr(0, 1'b1, 5'd7, 32'd1); set_wr(1, 1'b1, 5'd7, 32'd2); set_rd(1, 5'd7);
      exp_o("r7_byp", 1, 32'd2);
      exp_o("r7_byp_busy", 4, 32'h0);
      drain();
      tick();
      idle();
      exp_o("r7_stored", 1, 32'd2);
      exp_o("r7_busy", 4, 32'h0);
      exp_o("r7_err", 7, 32'h0);
      drain();

      // r3: saturate the counter, fourth issue ignored, drain three
      iss_en = 1'b1; iss_addr = 5'd3; set_rd(2, 5'd3);
      tick();
      exp_o("r3_ready1", 6, 32'h1); drain();
      tick();
      exp_o("r3_ready2", 6, 32'h1); drain();
      tick();
      exp_o("r3_ready3", 6, 32'h0); drain();
      tick();   // fourth issue while not ready
      idle();
      exp_o("r3_busy_full", 5, 32'h1); drain();
      set_wr(0, 1'b1, 5'd3, 32'h33);
      tick();   // 3 -> 2
      exp_o("r3_busy_wb1", 5, 32'h1); drain();
      tick();   // 2 -> 1, last retire in progress
      exp_o("r3_busy_last", 5, 32'h0);
      exp_o("r3_byp", 2, 32'h33);
      drain();
      idle();
      exp_o("r3_busy_hold", 5, 32'h1); drain();
      set_wr(0, 1'b1, 5'd3, 32'h34);
      tick();   // 1 -> 0
      idle();
      exp_o("r3_busy_done", 5, 32'h0);
      exp_o("r3_err", 7, 32'h0);
      drain();

      // r9: issue and retire in the same cycle keeps one pending
      iss_en = 1'b1; iss_addr = 5'd9;
      tick();
      set_wr(0, 1'b1, 5'd9, 32'h99);
      tick();
      idle(); set_rd(0, 5'd9);
      exp_o("r9_busy", 3, 32'h1);
      exp_o("r9_data", 0, 32'h99);
      drain();
      set_wr(1, 1'b1, 5'd9, 32'h9A);
      tick();
      idle();
      exp_o("r9_busy_done", 3, 32'h0);
      exp_o("r9_err", 7, 32'h0);
      drain();

      // r0: writes and issues have no effect
      iss_en = 1'b1; iss_addr = 5'd0; set_rd(0, 5'd0);
      set_wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      exp_o("r0_ready", 6, 32'h1);
      exp_o("r0_byp", 0, 32'h0);
      exp_o("r0_busy", 3, 32'h0);
      drain();
      tick(); tick(); tick(); tick();
      set_wr(1, 1'b0, 5'd0, 32'h0);
      exp_o("r0_ready_sat", 6, 32'h1);
      exp_o("r0_data", 0, 32'h0);
      exp_o("r0_busy2", 3, 32'h0);
      exp_o("r0_err", 7, 32'h0);
      drain();
      idle();

      // r4: write-back with nothing pending
      set_rd(1, 5'd4);
      set_wr(0, 1'b1, 5'd4, 32'h44);
      exp_o("r4_byp", 1, 32'h44);
      exp_o("r4_err_pre", 7, 32'h0);
      drain();
      tick();
      idle();
      exp_o("r4_stored", 1, 32'h44);
      exp_o("r4_err", 7, 32'h1);
      drain();
      tick();
      exp_o("r4_err_sticky", 7, 32'h1);
      drain();

      // reset mid-burst
      iss_en = 1'b1; iss_addr = 5'd2;
      set_wr(0, 1'b1, 5'd6, 32'h66);
      tick();
      set_rd(0, 5'd6); set_rd(1, 5'd2); set_rd(2, 5'd4);
      idle();
      exp_o("pre_rst_busy", 4, 32'h1);
      exp_o("pre_rst_data", 0, 32'h66);
      drain();
      reset = 1'b1;
      iss_addr = 5'd2;
      exp_o("mid_rst_r6", 0, 32'h0);
      exp_o("mid_rst_r4", 2, 32'h0);
      exp_o("mid_rst_busy", 4, 32'h0);
      exp_o("mid_rst_ready", 6, 32'h1);
      exp_o("mid_rst_err", 7, 32'h0);
      drain();
      tick();
      reset = 1'b0;
      tick();
      set_wr(0, 1'b1, 5'd2, 32'h22);
      tick();
      idle();
      exp_o("post_rst_err", 7, 32'h1);
      exp_o("post_rst_data", 1, 32'h22);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
